multiword_add_sub_seq: RTL and testbench
========================================

MULTIWORD_ADD_SUB_SEQ -- requirements
Module: multiword_add_sub_seq

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices processed per operation; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 mode  input  1  0 = add (a+b), 1 = subtract (a-b); captured with start.
REQ-006 a  input  W  operand A (two's complement or unsigned); captured with start.
REQ-007 b  input  W  operand B; captured with start.
REQ-008 busy  output  1  high while an operation is in progress (RUN or DONE).
REQ-009 done  output  1  one-cycle pulse; result and flags are valid from this cycle.
REQ-010 result  output  W  registered sum/difference.
REQ-011 carry_out  output  1  carry out of bit W-1; for subtract, 1 = no borrow.
REQ-012 overflow  output  1  signed two's-complement overflow of the W-bit operation.

Function
REQ-013 FSM states: IDLE, RUN, DONE.
REQ-014 IDLE with start=1: the block shall capture a, b and mode, clear the slice counter, load the internal carry with mode, and enter RUN.
REQ-015 IDLE with start=0: the block shall remain in IDLE.
REQ-016 RUN: each cycle one 4-bit slice, indexed LSB-first by a counter 0..NIBBLES-1, shall be computed as a_slice + (b_slice XOR {4{mode}}) + carry; the 4-bit sum is written to the matching nibble of an internal accumulator and the slice carry replaces the internal carry.
REQ-017 RUN: after the slice with index NIBBLES-1, the block shall enter DONE.
REQ-018 Overflow shall be computed on the MSB slice as (a[W-1] & b'[W-1] & ~s[W-1]) | (~a[W-1] & ~b'[W-1] & s[W-1]), where b' = b XOR {W{mode}}.
REQ-019 DONE: done=1 for exactly one cycle, and result/carry_out/overflow shall be loaded from the accumulator and final flags on entry to DONE; next state IDLE.
REQ-020 Latency: start accepted at edge T shall produce done=1 in the cycle after edge T+NIBBLES, i.e. NIBBLES+1 cycles start-to-done.
REQ-021 result, carry_out and overflow shall hold their last values until the next DONE; they shall not change during RUN.
REQ-022 start asserted in RUN or DONE shall be ignored with no queuing; operand inputs may change freely while busy without affecting the operation.
REQ-023 Back-to-back: start sampled in the IDLE cycle immediately following DONE shall be accepted, giving a throughput of one operation per NIBBLES+2 cycles.
REQ-024 busy shall be 1 in RUN and DONE and 0 in IDLE.

Reset
REQ-025 rst_n=0 shall asynchronously force state IDLE, busy=0, done=0, result=0, carry_out=0, overflow=0, and clear the counter, accumulator, internal carry and captured operands.
REQ-026 Reset asserted mid-RUN shall abort the operation; no done pulse shall be produced, and the first start after release shall be handled normally.

Structure
REQ-027 The state encoding typedef (IDLE/RUN/DONE) and the slice width constant (4) shall be defined in a shared package, multiword_add_sub_pkg.
REQ-028 A single sub-module, nibble_add_sub, shall be instantiated: 4-bit a, b, mode, cin in; 4-bit sum, cout out. It is combinational, with b inverted by mode and cin supplied externally.
REQ-029 The counter width shall be $clog2(NIBBLES), with a minimum of 1.

Verification (NIBBLES=4, W=16)
REQ-030 Add: a=0x1234, b=0x0FFF, mode=0 -> result=0x2233, carry_out=0, overflow=0, with done exactly 5 cycles after start is accepted.
REQ-031 Add boundaries: 0xFFFF+0x0001 -> result 0x0000, carry_out=1, overflow=0; 0x7FFF+0x0001 -> result 0x8000, carry_out=0, overflow=1.
REQ-032 Subtract: 0x0000-0x0001 -> result 0xFFFF, carry_out=0, overflow=0; 0x8000-0x0001 -> result 0x7FFF, carry_out=1, overflow=1.
REQ-033 Busy handling: a start pulse with different operands during RUN is ignored, and the first result is unchanged; start in the IDLE cycle after DONE is accepted, with busy rising on the next edge.
REQ-034 Reset mid-operation: rst_n low on the 2nd RUN cycle -> all outputs 0 immediately and no done pulse; the next operation 0x0001+0x0001 -> result 0x0002.
REQ-035 Random: 1000 random a/b/mode operations shall be checked against a W-bit reference model for result, carry_out and overflow.

Source files
------------

// File: rtl/multiword_add_sub_pkg.sv
// Shared types and constants for the nibble-serial add/subtract block.
package multiword_add_sub_pkg;

   localparam int unsigned SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Slice counter width: at least one bit even for a single-slice build.
   function automatic int unsigned cnt_width(input int unsigned slices);
      return (slices > 1) ? $clog2(slices) : 1;
   endfunction

endpackage

// File: rtl/nibble_add_sub.sv
// One 4-bit slice of the ripple adder/subtractor; b is inverted when mode=1.
module nibble_add_sub
   import multiword_add_sub_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               mode,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);

   logic [SLICE_W:0] full;

   assign full = {1'b0, a} + {1'b0, b ^ {SLICE_W{mode}}} + {{SLICE_W{1'b0}}, cin};
   assign sum  = full[SLICE_W-1:0];
   assign cout = full[SLICE_W];

endmodule

// File: rtl/multiword_add_sub_seq.sv
// Multi-word add/subtract that processes one 4-bit slice per cycle, LSB first,
// and publishes result and flags with a single-cycle done pulse.
module multiword_add_sub_seq
   import multiword_add_sub_pkg::*;
#(
   parameter  int unsigned NIBBLES = 4,
   localparam int unsigned W       = SLICE_W * NIBBLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         mode,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] result,
   output logic         carry_out,
   output logic         overflow
);

   localparam int unsigned CW = cnt_width(NIBBLES);

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q;
   logic                 carry_q;
   logic                 mode_q;
   logic [W-1:0]         a_q, b_q;
   logic [W-1:0]         acc_q;

   logic                 capture, step, last;
   logic [SLICE_W-1:0]   a_sl, b_sl, s_sum;
   logic                 s_cout;
   logic [W-1:0]         acc_nxt;
   logic                 ovf_c;

   // Next-state and datapath enables.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      step    = 1'b0;
      last    = (cnt_q == CW'(NIBBLES - 1));
      case (state_q)
         IDLE: begin
            if (start) begin
               capture = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Select the current operand slices from the captured words.
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int i = 0; i < int'(NIBBLES); i++) begin
         if (cnt_q == CW'(i)) begin
            a_sl = a_q[i*SLICE_W +: SLICE_W];
            b_sl = b_q[i*SLICE_W +: SLICE_W];
         end
      end
   end

   nibble_add_sub u_slice (
      .a    (a_sl),
      .b    (b_sl),
      .mode (mode_q),
      .cin  (carry_q),
      .sum  (s_sum),
      .cout (s_cout)
   );

   // Accumulator with the current slice merged in; used for the final result too.
   always_comb begin
      acc_nxt = acc_q;
      for (int i = 0; i < int'(NIBBLES); i++) begin
         if (cnt_q == CW'(i)) acc_nxt[i*SLICE_W +: SLICE_W] = s_sum;
      end
   end

   // Only meaningful on the MSB slice, where a_sl/b_sl/s_sum hold bit W-1.
   assign ovf_c = ( a_q[W-1] &  (b_q[W-1] ^ mode_q) & ~s_sum[SLICE_W-1]) |
                  (~a_q[W-1] & ~(b_q[W-1] ^ mode_q) &  s_sum[SLICE_W-1]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         mode_q    <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy    <= (state_d != IDLE);
         done    <= (state_d == DONE);
         if (capture) begin
            a_q     <= a;
            b_q     <= b;
            mode_q  <= mode;
            cnt_q   <= '0;
            carry_q <= mode;
         end
         if (step) begin
            acc_q   <= acc_nxt;
            carry_q <= s_cout;
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
               result    <= acc_nxt;
               carry_out <= s_cout;
               overflow  <= ovf_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_multiword_add_sub_seq.sv
// Self-checking bench for multiword_add_sub_seq with NIBBLES=4 (16-bit operands).
module tb_multiword_add_sub_seq;

   localparam int unsigned N = 4;
   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         start = 1'b0;
   logic         mode = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, carry_out, overflow;
   logic [W-1:0] result;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multiword_add_sub_seq #(.NIBBLES(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   // Reference: plain integer arithmetic on the operand values.
   function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                                 output logic [W-1:0] r, output logic c, output logic v);
      int sx, sy, sres, ures;
      sx   = int'($signed(x));
      sy   = int'($signed(y));
      sres = m ? (sx - sy) : (sx + sy);
      v    = (sres > 32767) || (sres < -32768);
      ures = m ? (int'(x) - int'(y)) : (int'(x) + int'(y));
      r    = ures[W-1:0];
      c    = m ? (x >= y) : ((int'(x) + int'(y)) > 65535);
   endfunction

   // Launch one operation and wait for done; operands are scrambled while busy.
   task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic m,
                        input bit sync, output int cyc, output bit ok, output bit busy1);
      if (sync) @(negedge clk);
      a = xa; b = xb; mode = m; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 1;
      @(negedge clk);
      busy1 = busy;
      while (!done && cyc < 20) begin
         a = W'($urandom); b = W'($urandom); mode = 1'($urandom);
         @(negedge clk);
         cyc++;
      end
      ok = done;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, result, carry_out, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b result=%h co=%b ov=%b, need all 0",
                  busy, done, result, carry_out, overflow);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                           input logic m);
      logic [W-1:0] er;
      logic ec, ev;
      int cyc;
      bit ok, b1;
      model(xa, xb, m, er, ec, ev);
      do_op(xa, xb, m, 1'b1, cyc, ok, b1);
      checks++;
      if (!ok || cyc != int'(N) + 1) begin
         errors++;
         $display("FAIL %s_latency: done seen=%b after %0d cycles, need %0d", name, ok, cyc, N + 1);
      end
      checks++;
      if ({result, carry_out, overflow} !== {er, ec, ev}) begin
         errors++;
         $display("FAIL %s: got result=%h co=%b ov=%b, need result=%h co=%b ov=%b",
                  name, result, carry_out, overflow, er, ec, ev);
      end
   endtask

   task automatic test_add();
      check_op("add_1234_0fff", 16'h1234, 16'h0FFF, 1'b0);
      checks++;
      if (result !== 16'h2233) begin
         errors++;
         $display("FAIL add_const: got %h need 2233", result);
      end
   endtask

   task automatic test_boundaries();
      check_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0);
      check_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0);
      check_op("sub_0000_0001", 16'h0000, 16'h0001, 1'b1);
      check_op("sub_8000_0001", 16'h8000, 16'h0001, 1'b1);
      checks++;
      if ({result, carry_out, overflow} !== {16'h7FFF, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL sub_const: got %h/%b/%b need 7fff/1/1", result, carry_out, overflow);
      end
   endtask

   task automatic test_busy_ignore();
      logic [W-1:0] prev;
      logic [W-1:0] er;
      logic ec, ev;
      int cyc;
      prev = result;
      model(16'h0102, 16'h0304, 1'b0, er, ec, ev);
      @(negedge clk);
      a = 16'h0102; b = 16'h0304; mode = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      a = 16'hAAAA; b = 16'h5555; mode = 1'b1; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 2;
      @(negedge clk);
      checks++;
      if (result !== prev) begin
         errors++;
         $display("FAIL hold_during_run: got %h need %h", result, prev);
      end
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (!done || cyc != int'(N) + 1 || result !== er || carry_out !== ec || overflow !== ev) begin
         errors++;
         $display("FAIL busy_ignore: done=%b cyc=%0d result=%h, need done at %0d result=%h",
                  done, cyc, result, N + 1, er);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_queue: cycle %0d got done=%b busy=%b need 0/0", i, done, busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] er;
      logic ec, ev;
      int cyc;
      bit ok, b1;
      do_op(16'h1111, 16'h2222, 1'b0, 1'b1, cyc, ok, b1);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: got busy=%b done=%b need 0/0", busy, done);
      end
      model(16'h5000, 16'h6000, 1'b1, er, ec, ev);
      do_op(16'h5000, 16'h6000, 1'b1, 1'b0, cyc, ok, b1);
      checks++;
      if (b1 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_busy: got busy=%b after accept, need 1", b1);
      end
      checks++;
      if (!ok || cyc != int'(N) + 1 || {result, carry_out, overflow} !== {er, ec, ev}) begin
         errors++;
         $display("FAIL b2b_result: done=%b cyc=%0d got %h/%b/%b need %h/%b/%b",
                  ok, cyc, result, carry_out, overflow, er, ec, ev);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [W-1:0] er;
      logic ec, ev;
      int cyc;
      bit ok, b1;
      @(negedge clk);
      a = 16'h9999; b = 16'h9999; mode = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, result, carry_out, overflow} !== '0) begin
         errors++;
         $display("FAIL midrun_reset: got busy=%b done=%b result=%h co=%b ov=%b need all 0",
                  busy, done, result, carry_out, overflow);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_done: cycle %0d got done=%b busy=%b need 0/0", i, done, busy);
         end
      end
      model(16'h0001, 16'h0001, 1'b0, er, ec, ev);
      do_op(16'h0001, 16'h0001, 1'b0, 1'b1, cyc, ok, b1);
      checks++;
      if (!ok || result !== 16'h0002 || result !== er || carry_out !== ec || overflow !== ev) begin
         errors++;
         $display("FAIL post_reset_op: done=%b got %h need 0002", ok, result);
      end
   endtask

   task automatic test_random();
      logic [W-1:0] xa, xb, er;
      logic m, ec, ev;
      int cyc;
      bit ok, b1;
      int bad;
      bad = 0;
      for (int i = 0; i < 1000; i++) begin
         xa = W'($urandom);
         xb = W'($urandom);
         m  = 1'($urandom);
         model(xa, xb, m, er, ec, ev);
         do_op(xa, xb, m, 1'b1, cyc, ok, b1);
         checks++;
         if (!ok || cyc != int'(N) + 1 || {result, carry_out, overflow} !== {er, ec, ev}) begin
            errors++;
            if (bad < 10)
               $display("FAIL random_%0d: %h %s %h got %h/%b/%b done=%b cyc=%0d need %h/%b/%b",
                        i, xa, m ? "-" : "+", xb, result, carry_out, overflow, ok, cyc, er, ec, ev);
            bad++;
         end
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_add();
      test_boundaries();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
